// File: rtl/decode_issue_queue_if.sv
// Handshake bundle between decode, the decode/issue queue and the issue stage.
// Signal suffixes (_i/_o) are named from the queue's point of view.
interface decode_issue_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]      decoded_instr_i;
    logic                   decoded_instr_valid_i;
    logic                   is_ctrl_flow_i;
    logic                   decoded_instr_ack_o;
    logic [DATA_W-1:0]      issue_instr_o;
    logic                   issue_instr_valid_o;
    logic                   issue_ack_i;
    logic                   resolve_branch_i;
    logic                   flush_unissued_instr_i;
    logic                   flush_i;
    logic [$clog2(DEPTH):0] count_o;
    logic                   branch_pending_o;

    // The queue itself
    modport slave (
        input  decoded_instr_i, decoded_instr_valid_i, is_ctrl_flow_i,
        input  issue_ack_i, resolve_branch_i, flush_unissued_instr_i, flush_i,
        output decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o,
        output count_o, branch_pending_o
    );

    // Decode / issue / execute environment driving the queue
    modport master (
        output decoded_instr_i, decoded_instr_valid_i, is_ctrl_flow_i,
        output issue_ack_i, resolve_branch_i, flush_unissued_instr_i, flush_i,
        input  decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o,
        input  count_o, branch_pending_o
    );
endinterface

// File: rtl/decode_issue_queue.sv
// In-order FIFO between decode and issue that holds back further issue while a
// control-flow instruction is unresolved, with partial and full flush.
module decode_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    decode_issue_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [DATA_W-1:0] scoreboard_entry_t;

    // Each slot holds {ctrl, instruction}
    logic [DATA_W:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               branch_pending_q, branch_pending_d;

    logic               any_flush;
    logic               push;
    logic               pop;
    logic               head_ctrl;
    logic [DEPTH-1:0]   wr_en;
    scoreboard_entry_t  head_instr;

    assign any_flush  = bus.flush_i || bus.flush_unissued_instr_i;
    assign head_instr = mem_q[rd_ptr_q][DATA_W-1:0];
    assign head_ctrl  = mem_q[rd_ptr_q][DATA_W];

    assign bus.decoded_instr_ack_o = (count_q != CNT_W'(DEPTH)) && !any_flush && !rst_i;
    assign bus.issue_instr_valid_o = (count_q != '0) && !branch_pending_q && !any_flush && !rst_i;
    assign bus.issue_instr_o       = head_instr;
    assign bus.count_o             = count_q;
    assign bus.branch_pending_o    = branch_pending_q;

    assign push = bus.decoded_instr_valid_i && bus.decoded_instr_ack_o;
    assign pop  = bus.issue_instr_valid_o && bus.issue_ack_i;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        branch_pending_d = branch_pending_q;
        count_d          = count_q + CNT_W'(push) - CNT_W'(pop);

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        // A resolve arriving with a new branch pop belongs to the older branch
        if (pop && head_ctrl) begin
            branch_pending_d = 1'b1;
        end else if (bus.resolve_branch_i) begin
            branch_pending_d = 1'b0;
        end

        // No push is accepted during a flush, so wr_ptr_q is already final
        if (any_flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end
        if (bus.flush_i) branch_pending_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q         <= '0;
            wr_ptr_q         <= '0;
            count_q          <= '0;
            branch_pending_q <= 1'b0;
        end else begin
            rd_ptr_q         <= rd_ptr_d;
            wr_ptr_q         <= wr_ptr_d;
            count_q          <= count_d;
            branch_pending_q <= branch_pending_d;
        end
    end

    // Storage is intentionally left out of reset
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) mem_q[i] <= {bus.is_ctrl_flow_i, bus.decoded_instr_i};
        end
    end
endmodule
